// File: rtl/nic_pkg.sv
// nic_pkg: shared ring slot types, ids and the saturating age helper.
package nic_pkg;
  localparam int ID_W = 6;
  localparam int AGE_W = 6;
  localparam int DATA_W = 16;
  localparam int VEC_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 6'h3F;
  typedef enum logic [1:0] {PT_NULL, PT_DATA, PT_CTRL, PT_IRQ} pkt_type_e;
  typedef struct packed {
    logic [ID_W-1:0] did;
    logic [ID_W-1:0] sid;
    logic [AGE_W-1:0] age;
    pkt_type_e typ;
    logic [DATA_W-1:0] data;
  } Packet;
  typedef struct packed {
    logic [ID_W-1:0] did;
    logic [ID_W-1:0] sid;
    logic [AGE_W-1:0] age;
    pkt_type_e typ;
    logic [VEC_W-1:0] vec;
  } IPacket;
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return &a ? a : a + AGE_W'(1);
  endfunction
endpackage

// File: rtl/nic_ring_tap_if.sv
// nic_ring_tap_if: ring slots, local TX/RX queues and interrupt handshake of one tap.
interface nic_ring_tap_if;
  import nic_pkg::*;
  logic [ID_W-1:0] id_i;
  Packet packet_i, packet_o, tx_packet_i, rx_packet_o;
  IPacket ipacket_i, ipacket_o, irq_packet_o;
  logic tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, irq_o, irq_ack_i, drop_o;
  modport slave (
    input id_i, packet_i, ipacket_i, tx_valid_i, tx_packet_i, rx_ready_i, irq_ack_i,
    output packet_o, ipacket_o, tx_ready_o, rx_valid_o, rx_packet_o, irq_o, irq_packet_o, drop_o
  );
  modport master (
    output id_i, packet_i, ipacket_i, tx_valid_i, tx_packet_i, rx_ready_i, irq_ack_i,
    input packet_o, ipacket_o, tx_ready_o, rx_valid_o, rx_packet_o, irq_o, irq_packet_o, drop_o
  );
endinterface

// File: rtl/nic_fifo.sv
// nic_fifo: synchronous Packet FIFO; push ignored when full, pop ignored when empty.
module nic_fifo
  import nic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  Packet din,
  input  logic pop,
  output Packet dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  Packet mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/nic_ring_tap.sv
// nic_ring_tap: ring attachment stage delivering, inserting, ageing and latching interrupts.
module nic_ring_tap
  import nic_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4,
  parameter logic [AGE_W-1:0] MAX_AGE = 6'd63
) (
  input logic clk_i,
  input logic rst_ni,
  nic_ring_tap_if.slave bus
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  Packet fwd, ins, tx_head, packet_d;
  IPacket ip_fwd, ipacket_d;
  logic slot_free, rx_push, rx_pop, tx_pop, drop_p, drop_i, ip_hit, irq_latch;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_AW:0] rx_count;
  logic [TX_AW:0] tx_count;
  logic unused_ok;
  assign unused_ok = ^{rx_count, tx_full};
  assign rx_pop = bus.rx_ready_i && !rx_empty;
  assign bus.rx_valid_o = !rx_empty;
  assign bus.tx_ready_o = tx_count != (TX_AW+1)'(TX_DEPTH);
  nic_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(rx_push), .din(bus.packet_i), .pop(rx_pop),
    .dout(bus.rx_packet_o), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  nic_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(bus.tx_valid_i), .din(bus.tx_packet_i), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  always_comb begin
    slot_free = 1'b0;
    rx_push = 1'b0;
    drop_p = 1'b0;
    fwd = bus.packet_i;
    if (bus.packet_i.typ == PT_NULL) slot_free = 1'b1;
    else if (bus.packet_i.did == bus.id_i) begin
      rx_push = !rx_full;
      slot_free = !rx_full;
      fwd.age = age_inc(bus.packet_i.age);
    end else if (bus.packet_i.did == BCAST_ID) begin
      slot_free = bus.packet_i.sid == bus.id_i;
      rx_push = !slot_free && !rx_full;
    end else if (bus.packet_i.age == MAX_AGE) begin
      slot_free = 1'b1;
      drop_p = 1'b1;
    end else fwd.age = age_inc(bus.packet_i.age);
    // a slot freed by delivery this cycle is immediately reusable for TX
    tx_pop = slot_free && !tx_empty;
    ins = tx_head;
    ins.sid = bus.id_i;
    ins.age = '0;
    packet_d = tx_pop ? ins : slot_free ? '0 : fwd;
    ip_hit = bus.ipacket_i.typ != PT_NULL && bus.ipacket_i.did == bus.id_i;
    irq_latch = ip_hit && (!bus.irq_o || bus.irq_ack_i);
    ip_fwd = bus.ipacket_i;
    drop_i = 1'b0;
    if (ip_hit && !irq_latch) begin
      drop_i = bus.ipacket_i.age == MAX_AGE;
      ip_fwd.age = age_inc(bus.ipacket_i.age);
    end
    ipacket_d = (irq_latch || drop_i) ? '0 : ip_fwd;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bus.packet_o <= '0;
      bus.ipacket_o <= '0;
      bus.irq_packet_o <= '0;
      bus.irq_o <= 1'b0;
      bus.drop_o <= 1'b0;
    end else begin
      bus.packet_o <= packet_d;
      bus.ipacket_o <= ipacket_d;
      bus.drop_o <= drop_p || drop_i;
      bus.irq_o <= irq_latch || (bus.irq_o && !bus.irq_ack_i);
      if (irq_latch) bus.irq_packet_o <= bus.ipacket_i;
    end
endmodule

// File: tb/tb_nic_ring_tap.sv
// tb_nic_ring_tap: directed plus random checks of nic_ring_tap against a queue-based model.
module tb_nic_ring_tap;
  import nic_pkg::*;
  localparam int RXD = 4;
  localparam int TXD = 4;
  localparam logic [5:0] MAXA = 6'd63;
  localparam logic [5:0] ID = 6'd5;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  nic_ring_tap_if bus();
  nic_ring_tap #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .MAX_AGE(MAXA)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  Packet rxq[$];
  Packet txq[$];
  logic irq_m;
  IPacket irqp_m;
  Packet e_p;
  IPacket e_ip;
  logic e_drop;

  function automatic Packet mk(input logic [5:0] did, sid, age, input pkt_type_e typ, input logic [15:0] data);
    Packet p;
    p.did = did; p.sid = sid; p.age = age; p.typ = typ; p.data = data;
    return p;
  endfunction

  function automatic IPacket mki(input logic [5:0] did, sid, age, input pkt_type_e typ, input logic [7:0] vec);
    IPacket p;
    p.did = did; p.sid = sid; p.age = age; p.typ = typ; p.vec = vec;
    return p;
  endfunction

  function automatic logic [5:0] sat(input logic [5:0] a);
    return (int'(a) + 1 > 63) ? 6'd63 : 6'(int'(a) + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("packet_o", 64'(bus.packet_o), 64'(e_p));
    chk("ipacket_o", 64'(bus.ipacket_o), 64'(e_ip));
    chk("drop_o", 64'(bus.drop_o), 64'(e_drop));
    chk("irq_o", 64'(bus.irq_o), 64'(irq_m));
    chk("irq_packet_o", 64'(bus.irq_packet_o), 64'(irqp_m));
    chk("tx_ready_o", 64'(bus.tx_ready_o), 64'(txq.size() < TXD));
    chk("rx_valid_o", 64'(bus.rx_valid_o), 64'(rxq.size() > 0));
    if (rxq.size() > 0) chk("rx_packet_o", 64'(bus.rx_packet_o), 64'(rxq[0]));
  endtask

  task automatic reset_model();
    rxq.delete();
    txq.delete();
    irq_m = 1'b0;
    irqp_m = '0;
    e_p = '0;
    e_ip = '0;
    e_drop = 1'b0;
  endtask

  task automatic idle();
    bus.packet_i = '0;
    bus.ipacket_i = '0;
    bus.tx_valid_i = 1'b0;
    bus.tx_packet_i = '0;
    bus.rx_ready_i = 1'b0;
    bus.irq_ack_i = 1'b0;
  endtask

  // predict the slot outputs from the current inputs and queue contents, then clock and compare
  task automatic tick();
    Packet p, f, ins;
    IPacket ip, ipf;
    bit free, push, dp, di, hit, tx_push, rx_pop;
    p = bus.packet_i;
    f = p;
    free = 0; push = 0; dp = 0; di = 0;
    tx_push = bus.tx_valid_i && txq.size() < TXD;
    rx_pop = bus.rx_ready_i && rxq.size() > 0;
    if (p.typ == PT_NULL) free = 1;
    else if (p.did == ID) begin
      if (rxq.size() < RXD) begin push = 1; free = 1; end
      else f.age = sat(p.age);
    end else if (p.did == 6'h3F) begin
      if (p.sid == ID) free = 1;
      else push = rxq.size() < RXD;
    end else if (p.age == MAXA) begin
      free = 1; dp = 1;
    end else f.age = sat(p.age);
    if (free && txq.size() > 0) begin
      ins = txq.pop_front();
      ins.sid = ID;
      ins.age = 6'd0;
      e_p = ins;
    end else e_p = free ? '0 : f;
    if (tx_push) txq.push_back(bus.tx_packet_i);
    if (rx_pop) void'(rxq.pop_front());
    if (push) rxq.push_back(p);
    ip = bus.ipacket_i;
    ipf = ip;
    hit = ip.typ != PT_NULL && ip.did == ID;
    if (hit && (!irq_m || bus.irq_ack_i)) begin
      irqp_m = ip;
      irq_m = 1'b1;
      e_ip = '0;
    end else begin
      if (bus.irq_ack_i) irq_m = 1'b0;
      if (hit) begin
        di = ip.age == MAXA;
        ipf.age = sat(ip.age);
        e_ip = di ? '0 : ipf;
      end else e_ip = ip;
    end
    e_drop = dp || di;
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  initial begin
    bus.id_i = ID;
    idle();
    reset_model();
    #12;
    rst_ni = 1'b1;
    #1;
    check_all();
    tick();
    bus.packet_i = mk(ID, 6'd2, 6'd0, PT_DATA, 16'hA5);
    tick();
    chk("hit_rx_data", 64'(bus.rx_packet_o.data), 64'h00A5);
    idle();
    bus.rx_ready_i = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.packet_i = mk(ID, 6'd1, 6'd0, PT_DATA, 16'(i));
      tick();
    end
    bus.packet_i = mk(ID, 6'd1, 6'd2, PT_DATA, 16'd99);
    tick();
    chk("full_fwd_age", 64'(bus.packet_o.age), 64'd3);
    idle();
    bus.rx_ready_i = 1'b1;
    repeat (4) tick();
    idle();
    bus.tx_valid_i = 1'b1;
    bus.tx_packet_i = mk(6'd9, 6'd0, 6'd0, PT_DATA, 16'h1234);
    bus.packet_i = mk(6'd7, 6'd2, 6'd1, PT_DATA, 16'd1);
    tick();
    bus.tx_valid_i = 1'b0;
    tick();
    bus.packet_i = '0;
    tick();
    chk("tx_insert_sid", 64'(bus.packet_o.sid), 64'(ID));
    bus.packet_i = mk(6'h3F, 6'd3, 6'd4, PT_DATA, 16'hBB);
    tick();
    bus.packet_i = mk(6'h3F, ID, 6'd4, PT_DATA, 16'hCC);
    tick();
    idle();
    bus.rx_ready_i = 1'b1;
    tick();
    idle();
    bus.packet_i = mk(6'd8, 6'd2, 6'd63, PT_DATA, 16'd7);
    tick();
    chk("aged_drop", 64'(bus.drop_o), 64'd1);
    bus.packet_i = mk(6'd8, 6'd2, 6'd10, PT_DATA, 16'd8);
    tick();
    idle();
    bus.ipacket_i = mki(ID, 6'd2, 6'd0, PT_IRQ, 8'd7);
    tick();
    bus.ipacket_i = mki(ID, 6'd3, 6'd4, PT_IRQ, 8'd8);
    tick();
    idle();
    bus.irq_ack_i = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 3);
      bus.packet_i = mk(r == 0 ? ID : r == 1 ? 6'h3F : 6'($urandom_range(0, 62)),
                        $urandom_range(0, 1) == 0 ? ID : 6'($urandom_range(0, 63)),
                        $urandom_range(0, 7) == 0 ? 6'd63 : 6'($urandom_range(0, 62)),
                        pkt_type_e'($urandom_range(0, 3)), 16'($urandom));
      bus.ipacket_i = mki($urandom_range(0, 1) == 0 ? ID : 6'($urandom_range(0, 63)),
                          6'($urandom_range(0, 63)),
                          $urandom_range(0, 5) == 0 ? 6'd63 : 6'($urandom_range(0, 62)),
                          pkt_type_e'($urandom_range(0, 3)), 8'($urandom));
      bus.tx_valid_i = $urandom_range(0, 1) == 1;
      bus.tx_packet_i = mk(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                           6'($urandom_range(0, 63)), PT_DATA, 16'($urandom));
      bus.rx_ready_i = $urandom_range(0, 2) == 0;
      bus.irq_ack_i = $urandom_range(0, 3) == 0;
      tick();
      if (i == 200) begin
        #3;
        rst_ni = 1'b0;
        #1;
        reset_model();
        check_all();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nic_ring_tap.md
Name: nic_ring_tap

Overview:
- Node attachment stage on the NIC ring. Sits between two nic_prop stages: it takes the ring slot from the upstream stage and drives the slot for the downstream stage.
- Delivers packets addressed to this node into an RX FIFO.
- Inserts locally queued TX packets into empty ring slots.
- Ages circulating packets.
- Latches interrupt packets addressed to this node.

Parameters:
- RX_DEPTH, 4: RX FIFO entries (power of 2, ≥2).
- TX_DEPTH, 4: TX FIFO entries (power of 2, ≥2).
- MAX_AGE, 6'd63: age at which a circulating packet is discarded.

Ports:
- clk_i  in  1  ring clock
- rst_ni  in  1  async active-low reset
- id_i  in  6  this node's ring id (static after reset)
- packet_i  in  Packet  ring slot from upstream
- packet_o  out  Packet  ring slot to downstream
- ipacket_i  in  IPacket  interrupt slot from upstream
- ipacket_o  out  IPacket  interrupt slot to downstream
- tx_valid_i  in  1  local TX request
- tx_packet_i  in  Packet  local TX packet (did, typ, data used)
- tx_ready_o  out  1  TX FIFO not full
- rx_valid_o  out  1  RX FIFO not empty
- rx_packet_o  out  Packet  RX FIFO head
- rx_ready_i  in  1  pop RX head
- irq_o  out  1  pending interrupt
- irq_packet_o  out  IPacket  latched interrupt packet
- irq_ack_i  in  1  clear pending interrupt
- drop_o  out  1  one-cycle pulse: aged packet discarded

Behaviour:
- Reset (async assert, sync deassert by the clock domain) clears the following to zero, i.e. null slots:
  - packet_o, ipacket_o, irq_packet_o
  - irq_o, drop_o, rx_valid_o
  - both FIFOs
- tx_ready_o is 1 after reset.
- Ring latency is exactly 1 cycle, the same as nic_prop. Every cycle packet_o/ipacket_o are registered from the decision below.
- Slot decision order per cycle:
  1. Null slot (typ==PT_NULL): candidate empty.
  2. Unicast hit (did==id_i):
     - RX FIFO not full: push to RX, slot becomes empty.
     - RX FIFO full: forward with age+1.
  3. Broadcast (did==BCAST_ID):
     - sid==id_i: slot becomes empty. The packet has completed a lap and is not pushed.
     - Otherwise: push to RX if not full, and forward unchanged in both cases. A full RX FIFO means this node misses the broadcast.
  4. Other packet:
     - age==MAX_AGE: slot becomes empty and drop_o pulses.
     - Otherwise: forward with age+1.
- If the slot is empty after step 1–4 and the TX FIFO is not empty, pop the TX head into packet_o with sid=id_i and age=0. Otherwise packet_o is null.
  - This includes a slot freed by delivery in the same cycle, so a node may deliver and insert in one cycle.
- Age never wraps. Saturation is handled by the discard at MAX_AGE.
- TX FIFO push occurs when tx_valid_i && tx_ready_o. Push and pop in the same cycle while full is not allowed: tx_ready_o is registered from the count.
- RX FIFO pop occurs when rx_valid_o && rx_ready_i. rx_packet_o is the head, combinationally valid while rx_valid_o.
  - Simultaneous push and pop while full: the pop frees space. Push acceptance uses the pre-pop full flag, so the ring packet recirculates. This is conservative and intentional.
- Interrupt path: ipacket_i with did==id_i and typ!=PT_NULL, while irq_o==0:
  - Latch it into irq_packet_o and set irq_o.
  - ipacket_o becomes null.
- If irq_o is already 1, a hit is forwarded with age+1, or dropped at MAX_AGE with drop_o pulsing.
- irq_ack_i clears irq_o next cycle. Ack and a new hit in the same cycle: the new hit is latched and irq_o stays 1.
- drop_o pulses for the packet-slot drop or the ipacket drop. Both in one cycle produce a single pulse.
- Reset mid-operation: all queued packets are lost, with no flush handshake.

Decomposition:
- nic_pkg additions:
  - PT_NULL
  - BCAST_ID (6'h3F)
  - AGE_W (6)
  - ID_W (6)
  - Packet field names did/sid/age/typ/data and IPacket did/sid/age/typ/vec
- One sub-module, nic_fifo: a parameterised synchronous FIFO of Packet with push/pop/full/empty/count, instantiated twice.

Test Plan:
- id_i=5; send packet did=5 typ=DATA data=0xA5 on packet_i → cycle+1: packet_o null, rx_valid_o=1, rx_packet_o.data=0xA5.
- Fill RX (4 hits, rx_ready_i=0), then send 5th hit with age=2 → packet_o is the same packet with age=3; rx count stays 4.
- tx_valid_i with did=9, then null slot on packet_i → packet_o sid=5 did=9 age=0, tx_ready_o=1. Repeat with a non-null transit slot → no insertion until a null slot arrives.
- Broadcast from sid=3 → pushed to RX and forwarded unchanged. Broadcast with sid=5 → slot null, no push.
- Transit packet age=63 → packet_o null, drop_o=1 for one cycle; age=10 → forwarded with age=11.
- ipacket did=5 vec=7 → irq_o=1, ipacket_o null. Second hit while pending → forwarded with age+1. Then irq_ack_i → irq_o=0. Assert rst_ni low mid-traffic → all outputs zero asynchronously.
